// File: rtl/id_stage_pkg.sv
// Shared constants for the instruction-decode stage: opcodes, field positions, widths.
package id_stage_pkg;
    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int IMM_W  = 5;
    localparam int OP_W   = 5;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 11;
    localparam int RD_HI  = 10;
    localparam int RD_LO  = 8;
    localparam int RS1_HI = 7;
    localparam int RS1_LO = 5;
    localparam int RS2_HI = 4;
    localparam int RS2_LO = 2;
    localparam int IMM_HI = 4;
    localparam int IMM_LO = 0;

    localparam logic [OP_W-1:0] OP_NOP   = 5'h00;
    localparam logic [OP_W-1:0] OP_ADD   = 5'h01;
    localparam logic [OP_W-1:0] OP_SUB   = 5'h02;
    localparam logic [OP_W-1:0] OP_AND   = 5'h03;
    localparam logic [OP_W-1:0] OP_OR    = 5'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 5'h08;
    localparam logic [OP_W-1:0] OP_LOAD  = 5'h10;
    localparam logic [OP_W-1:0] OP_STORE = 5'h11;

    localparam logic [DATA_W-1:0] ZERO16 = '0;
endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decode; read enables here are not yet qualified by IF valid.
module id_decoder
    import id_stage_pkg::*;
#(
    parameter int DW = id_stage_pkg::DATA_W,
    parameter int IW = id_stage_pkg::IMM_W
) (
    input  logic [DW-1:0] inst_i,
    output logic          rd1en_o,
    output logic          rd2en_o,
    output logic          regWrite_o,
    output logic          memRead_o,
    output logic          memWrite_o,
    output logic          illegal_o,
    output logic          useImm_o,
    output logic [DW-1:0] imm_o
);
    logic [OP_W-1:0] op;

    assign op    = inst_i[OP_HI:OP_LO];
    assign imm_o = {{(DW-IW){inst_i[IW-1]}}, inst_i[IW-1:0]};

    always_comb begin
        rd1en_o    = 1'b0;
        rd2en_o    = 1'b0;
        regWrite_o = 1'b0;
        memRead_o  = 1'b0;
        memWrite_o = 1'b0;
        illegal_o  = 1'b0;
        useImm_o   = 1'b0;
        case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                rd1en_o    = 1'b1;
                rd2en_o    = 1'b1;
                regWrite_o = 1'b1;
            end
            OP_ADDI: begin
                rd1en_o    = 1'b1;
                regWrite_o = 1'b1;
                useImm_o   = 1'b1;
            end
            OP_LOAD: begin
                rd1en_o    = 1'b1;
                regWrite_o = 1'b1;
                memRead_o  = 1'b1;
                useImm_o   = 1'b1;
            end
            OP_STORE: begin
                rd1en_o    = 1'b1;
                rd2en_o    = 1'b1;
                memWrite_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/id_stage.sv
// Decode stage: drives register-file reads, detects load-use hazards and owns the ID/EX register.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DATA_W = id_stage_pkg::DATA_W,
    parameter int REG_W  = id_stage_pkg::REG_W,
    parameter int IMM_W  = id_stage_pkg::IMM_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              if_valid_i,
    input  logic [DATA_W-1:0] if_inst_i,
    input  logic [DATA_W-1:0] if_pc_i,
    output logic              stall_o,
    input  logic              flush_i,
    input  logic              ex_stall_i,
    output logic [REG_W-1:0]  rg_reg1_o,
    output logic [REG_W-1:0]  rg_reg2_o,
    output logic              rg_reg1Read_o,
    output logic              rg_reg2Read_o,
    input  logic [DATA_W-1:0] rg_data1_i,
    input  logic [DATA_W-1:0] rg_data2_i,
    output logic              ex_valid_o,
    output logic [4:0]        ex_op_o,
    output logic [REG_W-1:0]  ex_rd_o,
    output logic              ex_regWrite_o,
    output logic              ex_memRead_o,
    output logic              ex_memWrite_o,
    output logic [DATA_W-1:0] ex_a_o,
    output logic [DATA_W-1:0] ex_b_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic              ex_illegal_o
);
    logic              dec_rd1en, dec_rd2en, dec_rw, dec_mr, dec_mw, dec_ill, dec_useImm;
    logic [DATA_W-1:0] dec_imm;
    logic              rd1en, rd2en, hazard;
    logic [REG_W-1:0]  rd, rs1, rs2;

    logic              valid_q, valid_d;
    logic [4:0]        op_q, op_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic              rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, ill_q, ill_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, pc_q, pc_d;

    id_decoder #(.DW(DATA_W), .IW(IMM_W)) u_dec (
        .inst_i     (if_inst_i),
        .rd1en_o    (dec_rd1en),
        .rd2en_o    (dec_rd2en),
        .regWrite_o (dec_rw),
        .memRead_o  (dec_mr),
        .memWrite_o (dec_mw),
        .illegal_o  (dec_ill),
        .useImm_o   (dec_useImm),
        .imm_o      (dec_imm)
    );

    assign rd  = if_inst_i[RD_HI:RD_LO];
    assign rs1 = if_inst_i[RS1_HI:RS1_LO];
    assign rs2 = if_inst_i[RS2_HI:RS2_LO];

    assign rd1en         = if_valid_i & dec_rd1en;
    assign rd2en         = if_valid_i & dec_rd2en;
    assign rg_reg1_o     = rs1;
    assign rg_reg2_o     = rs2;
    assign rg_reg1Read_o = rd1en;
    assign rg_reg2Read_o = rd2en;

    // A load in EX cannot forward its data yet, so a dependent instruction waits one cycle.
    assign hazard  = valid_q & mr_q & if_valid_i &
                     ((rd1en & (rd_q == rs1)) | (rd2en & (rd_q == rs2)));
    assign stall_o = if_valid_i & ~flush_i & (ex_stall_i | hazard);

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        ill_d   = ill_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (ex_stall_i) begin
            valid_d = valid_q;
        end else if (hazard) begin
            valid_d = 1'b0;
        end else begin
            valid_d = if_valid_i;
            op_d    = if_inst_i[OP_HI:OP_LO];
            rd_d    = rd;
            rw_d    = dec_rw;
            mr_d    = dec_mr;
            mw_d    = dec_mw;
            ill_d   = dec_ill;
            a_d     = rg_data1_i;
            b_d     = dec_useImm ? dec_imm : rg_data2_i;
            imm_d   = dec_imm;
            pc_d    = if_pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            ill_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            ill_q   <= ill_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
        end
    end

    assign ex_valid_o    = valid_q;
    assign ex_op_o       = op_q;
    assign ex_rd_o       = rd_q;
    assign ex_regWrite_o = rw_q;
    assign ex_memRead_o  = mr_q;
    assign ex_memWrite_o = mw_q;
    assign ex_illegal_o  = ill_q;
    assign ex_a_o        = a_q;
    assign ex_b_o        = b_q;
    assign ex_imm_o      = imm_q;
    assign ex_pc_o       = pc_q;
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage directly upstream of the register file.
- Takes the 16-bit instruction from IF and decodes it.
- Drives the register file read ports (reg1_i/reg2_i/reg1Read_i/reg2Read_i) and captures data1_o/data2_o.
- Registers everything into the ID/EX pipeline register. Detects load-use hazards and inserts one bubble; honours downstream stall and branch flush.

Parameters:
- DATA_W, 16, data/instruction width (matches the register file data width).
- REG_W, 3, register index width (8 registers).
- IMM_W, 5, immediate field width; sign-extended to DATA_W.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- if_valid_i  in  1  IF/ID holds a valid instruction
- if_inst_i  in  DATA_W  instruction
- if_pc_i  in  DATA_W  PC of the instruction
- stall_o  out  1  hold IF/ID and PC this cycle
- flush_i  in  1  branch taken: kill the instruction entering ID/EX
- ex_stall_i  in  1  EX cannot accept; hold ID/EX
- rg_reg1_o  out  REG_W  register file read index 1
- rg_reg2_o  out  REG_W  register file read index 2
- rg_reg1Read_o  out  1  read enable 1
- rg_reg2Read_o  out  1  read enable 2
- rg_data1_i  in  DATA_W  register file read data 1 (includes same-cycle write bypass)
- rg_data2_i  in  DATA_W  register file read data 2
- ex_valid_o  out  1  ID/EX valid
- ex_op_o  out  5  opcode
- ex_rd_o  out  REG_W  destination register
- ex_regWrite_o  out  1  writes rd
- ex_memRead_o  out  1  load
- ex_memWrite_o  out  1  store
- ex_a_o  out  DATA_W  operand A
- ex_b_o  out  DATA_W  operand B
- ex_imm_o  out  DATA_W  sign-extended immediate
- ex_pc_o  out  DATA_W  PC
- ex_illegal_o  out  1  undefined opcode

Behaviour:
- Instruction format: op=[15:11], rd=[10:8], rs1=[7:5], rs2=[4:2], imm=[4:0].
- Decode is combinational in ID. Read enables are asserted only when if_valid_i=1.
- ADD 01, SUB 02, AND 03, OR 04: read rs1 and rs2; regWrite=1.
- ADDI 08: read rs1; regWrite=1.
- LOAD 10: read rs1; regWrite=1; memRead=1.
- STORE 11: read rs1 and rs2; regWrite=0; memWrite=1.
- NOP 00: no reads, no write. Any other opcode behaves as NOP with illegal=1.
- ex_b_o takes rg_data2_i for reads of rs2 (including STORE). For ADDI/LOAD it takes the immediate. The STORE address is A+imm and its data is B.
- Disabled read ports return 0 from the register file. Those values are still captured.
- hazard = ex_valid_o & ex_memRead_o & if_valid_i & ((rd1en & ex_rd_o==rs1) | (rd2en & ex_rd_o==rs2)).
- stall_o = if_valid_i & !flush_i & (ex_stall_i | hazard), combinational.
- ID/EX update priority per clock edge:
  - 1) flush_i: ex_valid_o<=0, all other fields unchanged.
  - 2) ex_stall_i: hold all fields.
  - 3) hazard: bubble, ex_valid_o<=0.
  - 4) otherwise: capture the decode; ex_valid_o<=if_valid_i.
- Exactly one bubble per load-use, because the load then leaves EX.
- Latency: instruction present in ID at cycle N appears on ex_* at N+1.
- Reset (asynchronous assert, synchronous release via the clock domain): all ex_* outputs 0, ex_valid_o=0. stall_o follows its equation and is 0 when if_valid_i=0.
- Reset mid-stall drops the held instruction; no replay.
- Register 0 is a normal register; it is not hardwired to zero.

Decomposition:
- Shared package/defines: opcode constants (OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LOAD, OP_STORE), instruction field bit positions, DATA_W/REG_W, ZERO16.
- Sub-module id_decoder (pure combinational): instruction in; read enables, regWrite, memRead, memWrite, illegal, useImm, sign-extended immediate out.
- The top level holds the hazard logic and the ID/EX register.

Test Plan:
- Reset: assert rst_n_i=0 mid-stream -> immediately ex_valid_o=0, all ex_*=0. Release, then ADD r1,r2,r3 with RF r2=5, r3=7 -> next cycle ex_a_o=5, ex_b_o=7, ex_rd_o=1, ex_regWrite_o=1.
- ADDI r4,r1,imm=5'h1F -> ex_imm_o=16'hFFFF and ex_b_o=16'hFFFF. rg_reg2Read_o=0 during ID.
- Load-use: LOAD r2,[r1+0] then ADD r3,r2,r2:
  - cycle with ADD in ID -> stall_o=1; next cycle ex_valid_o=0.
  - following cycle ADD issues with ex_valid_o=1; stall_o=0.
- Load then independent ADD r3,r4,r5 -> no stall; back-to-back valid.
- ex_stall_i=1 for 3 cycles with SUB in ID -> stall_o=1, ex_* frozen. After release, SUB appears one cycle later.
- flush_i=1 with ex_stall_i=1 and a hazard present -> ex_valid_o=0 next cycle, stall_o=0.
- Opcode 5'h1F -> ex_illegal_o=1, regWrite/memRead/memWrite=0, ex_valid_o=1.
